// File: rtl/dataram_ctrl_pkg.sv
// Shared types and constants for the DATARAM access controller.
// Holds FSM state encoding, latched-request record and RAM idle levels.
package dataram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IND  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic       rw;
    logic       bb;
    logic       ind;
    logic [7:0] addr;
    logic [7:0] pos;
    logic [7:0] din;
    logic       bin;
  } req_t;

  localparam logic       RAM_CS_IDLE   = 1'b1;
  localparam logic       RAM_RW_IDLE   = 1'b1;
  localparam logic       RAM_BB_IDLE   = 1'b1;
  localparam logic       RAM_BIN_IDLE  = 1'b0;
  localparam logic [7:0] RAM_ADDR_IDLE = 8'h00;
  localparam logic [7:0] RAM_POS_IDLE  = 8'h00;
  localparam logic [7:0] RAM_DIN_IDLE  = 8'h00;

endpackage

// File: rtl/dataram_ctrl_arb.sv
// Two-requester arbiter: r1 normally wins, but never twice in a row
// while r0 is waiting.
module dataram_arb (
  input  logic req0,
  input  logic req1,
  input  logic last_r1,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant1 = req1 & ~(req0 & last_r1);
    grant0 = req0 & ~grant1;
  end

endmodule

// File: rtl/dataram_ctrl.sv
// DATARAM access controller: arbitrates core (r0) and stack (r1) requests,
// optionally fetches an @Ri pointer, then performs one RAM access.
module dataram_ctrl
  import dataram_ctrl_pkg::*;
#(
  parameter bit IND_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_req,
  input  logic       r0_rw,
  input  logic       r0_bb,
  input  logic       r0_ind,
  input  logic [7:0] r0_addr,
  input  logic [7:0] r0_pos,
  input  logic [7:0] r0_din,
  input  logic       r0_bin,
  output logic       r0_ack,
  input  logic       r1_req,
  input  logic       r1_rw,
  input  logic [7:0] r1_addr,
  input  logic [7:0] r1_din,
  output logic       r1_ack,
  output logic [7:0] rdata,
  output logic       rbit,
  output logic       ram_cs,
  output logic       ram_rw,
  output logic       ram_bb,
  output logic       ram_bin,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_pos,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout,
  input  logic       ram_bout
);

  state_t     state_reg, state_next;
  req_t       lat_reg;
  logic       who_reg;      // 1 = current access belongs to r1
  logic       last_r1_reg;
  logic [7:0] ptr_reg;
  logic [7:0] rdata_reg;
  logic       rbit_reg;
  logic       grant0, grant1;
  logic       granting;

  dataram_arb u_arb (
    .req0    (r0_req),
    .req1    (r1_req),
    .last_r1 (last_r1_reg),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  assign granting = (state_reg == IDLE) && (grant0 || grant1);
  assign rdata    = rdata_reg;
  assign rbit     = rbit_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      lat_reg     <= '0;
      who_reg     <= 1'b0;
      last_r1_reg <= 1'b0;
      ptr_reg     <= 8'h00;
      rdata_reg   <= 8'h00;
      rbit_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (granting) begin
        who_reg     <= grant1;
        last_r1_reg <= grant1;
        // r1 is byte-only, direct-only, bank 0
        if (grant1) begin
          lat_reg.rw   <= r1_rw;
          lat_reg.bb   <= 1'b1;
          lat_reg.ind  <= 1'b0;
          lat_reg.addr <= r1_addr;
          lat_reg.pos  <= 8'h00;
          lat_reg.din  <= r1_din;
          lat_reg.bin  <= 1'b0;
        end else begin
          lat_reg.rw   <= r0_rw;
          lat_reg.bb   <= r0_bb;
          lat_reg.ind  <= r0_ind & IND_EN;
          lat_reg.addr <= r0_addr;
          lat_reg.pos  <= r0_pos;
          lat_reg.din  <= r0_din;
          lat_reg.bin  <= r0_bin;
        end
      end
      if (state_reg == IND) begin
        ptr_reg <= ram_dout;
      end
      if (state_reg == ACC && lat_reg.rw) begin
        rdata_reg <= ram_dout;
        rbit_reg  <= ram_bout;
      end
    end
  end

  // RAM strobes are decoded from state so reset deasserts CS at once.
  always_comb begin
    state_next = state_reg;
    ram_cs     = RAM_CS_IDLE;
    ram_rw     = RAM_RW_IDLE;
    ram_bb     = RAM_BB_IDLE;
    ram_bin    = RAM_BIN_IDLE;
    ram_addr   = RAM_ADDR_IDLE;
    ram_pos    = RAM_POS_IDLE;
    ram_din    = RAM_DIN_IDLE;
    r0_ack     = 1'b0;
    r1_ack     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant0 || grant1) begin
          state_next = (grant0 && r0_ind && IND_EN) ? IND : ACC;
        end
      end
      IND: begin
        ram_cs     = 1'b0;
        ram_rw     = 1'b1;
        ram_bb     = 1'b1;
        ram_addr   = lat_reg.addr;
        ram_pos    = lat_reg.pos;
        state_next = ACC;
      end
      ACC: begin
        ram_cs     = 1'b0;
        ram_rw     = lat_reg.rw;
        ram_bb     = lat_reg.bb;
        ram_addr   = lat_reg.ind ? ptr_reg : lat_reg.addr;
        ram_pos    = lat_reg.pos;
        ram_din    = lat_reg.din;
        ram_bin    = lat_reg.bin;
        state_next = DONE;
      end
      DONE: begin
        r0_ack     = ~who_reg;
        r1_ack     = who_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dataram_ctrl.sv
// Self-checking bench for dataram_ctrl: directed vector table, arbitration
// and reset-abort sequences, then random traffic against a RAM shadow model.
module tb_dataram_ctrl;

  logic       clk, rst;
  logic       r0_req, r0_rw, r0_bb, r0_ind, r0_bin, r0_ack;
  logic [7:0] r0_addr, r0_pos, r0_din;
  logic       r1_req, r1_rw, r1_ack;
  logic [7:0] r1_addr, r1_din;
  logic [7:0] rdata;
  logic       rbit;
  logic       ram_cs, ram_rw, ram_bb, ram_bin;
  logic [7:0] ram_addr, ram_pos, ram_din, ram_dout;
  logic       ram_bout;

  int checks = 0;
  int errors = 0;

  dataram_ctrl #(.IND_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_bb(r0_bb), .r0_ind(r0_ind),
    .r0_addr(r0_addr), .r0_pos(r0_pos), .r0_din(r0_din), .r0_bin(r0_bin),
    .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_din(r1_din),
    .r1_ack(r1_ack),
    .rdata(rdata), .rbit(rbit),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_bb(ram_bb), .ram_bin(ram_bin),
    .ram_addr(ram_addr), .ram_pos(ram_pos), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_bout(ram_bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DATARAM stand-in: asynchronous read, write (byte or bit merge) at edge
  logic [7:0] mem [256];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (!ram_cs && !ram_rw) begin
      if (ram_bb) mem[ram_addr] <= ram_din;
      else        mem[ram_addr][ram_pos[2:0]] <= ram_bin;
    end
  end
  assign ram_dout = mem[ram_addr];
  assign ram_bout = ram_dout[ram_pos[2:0]];

  // Reference model: transaction-level view of memory plus held read result
  logic [7:0] shadow [256];
  logic [7:0] m_rd;
  bit         m_rb;

  task automatic model(input bit rw, input bit bb, input bit ind,
                       input logic [7:0] addr, input logic [7:0] pos,
                       input logic [7:0] din, input bit bin,
                       output logic [7:0] erd, output bit erb,
                       output logic [7:0] ptr);
    logic [7:0] eff;
    ptr = shadow[addr];
    eff = ind ? ptr : addr;
    if (rw) begin
      m_rd = shadow[eff];
      m_rb = shadow[eff][pos[2:0]];
    end else if (bb) begin
      shadow[eff] = din;
    end else begin
      shadow[eff][pos[2:0]] = bin;
    end
    erd = m_rd;
    erb = m_rb;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] ram_bus();
    return {ram_cs, ram_rw, ram_bb, ram_bin, ram_addr, ram_pos, ram_din};
  endfunction

  localparam logic [27:0] RAM_IDLE_BUS = 28'hE000000;

  task automatic scramble(input bit who);
    if (who) begin
      r1_rw = 1'($urandom); r1_addr = 8'($urandom); r1_din = 8'($urandom);
    end else begin
      r0_rw = 1'($urandom); r0_bb = 1'($urandom); r0_ind = 1'($urandom);
      r0_addr = 8'($urandom); r0_pos = 8'($urandom); r0_din = 8'($urandom);
      r0_bin = 1'($urandom);
    end
  endtask

  // One complete request/ack handshake; expectations supplied by caller
  task automatic txn(input string tag, input bit who, input bit rw, input bit bb,
                     input bit ind, input logic [7:0] addr, input logic [7:0] pos,
                     input logic [7:0] din, input bit bin, input logic [7:0] ptr,
                     input logic [7:0] erd, input bit erb);
    int lat = 0, ncs = 0;
    bit got = 0, other = 0;
    logic [7:0] cs_a0 = 8'h00, cs_a1 = 8'h00;
    logic a_rw = 1'b1, a_bb = 1'b1, a_bin = 1'b0;
    logic [7:0] a_pos = 8'h00, a_din = 8'h00, g_rd = 8'h00;
    logic g_rb = 1'b0;
    logic [27:0] g_bus = '0;
    @(negedge clk);
    if (who) begin
      r1_req = 1; r1_rw = rw; r1_addr = addr; r1_din = din;
    end else begin
      r0_req = 1; r0_rw = rw; r0_bb = bb; r0_ind = ind; r0_addr = addr;
      r0_pos = pos; r0_din = din; r0_bin = bin;
    end
    @(posedge clk);
    #1 scramble(who);
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (!ram_cs) begin
        if (ncs == 0) cs_a0 = ram_addr; else cs_a1 = ram_addr;
        ncs++;
        a_rw = ram_rw; a_bb = ram_bb; a_pos = ram_pos; a_din = ram_din; a_bin = ram_bin;
      end
      if (who ? r0_ack : r1_ack) other = 1;
      if (who ? r1_ack : r0_ack) begin
        got = 1; g_bus = ram_bus(); g_rd = rdata; g_rb = rbit;
        if (who) r1_req = 0; else r0_req = 0;
      end
    end
    r0_req = 0; r1_req = 0;
    $display("%s who=%0d rw=%0d bb=%0d ind=%0d addr=%02h pos=%02h din=%02h lat=%0d rdata=%02h rbit=%0d",
             tag, who, rw, bb, ind, addr, pos, din, lat, g_rd, g_rb);
    chk({tag, ".latency"}, lat, ind ? 3 : 2);
    chk({tag, ".cs_cycles"}, ncs, ind ? 2 : 1);
    chk({tag, ".addr0"}, cs_a0, addr);
    if (ind) chk({tag, ".ptr_addr"}, cs_a1, ptr);
    chk({tag, ".acc_rw"}, a_rw, rw);
    chk({tag, ".acc_bb"}, a_bb, bb);
    chk({tag, ".acc_pos"}, a_pos, pos);
    if (!rw && bb)  chk({tag, ".acc_din"}, a_din, din);
    if (!rw && !bb) chk({tag, ".acc_bin"}, a_bin, bin);
    chk({tag, ".other_ack"}, other, 0);
    chk({tag, ".idle_at_ack"}, g_bus, RAM_IDLE_BUS);
    chk({tag, ".rdata"}, g_rd, erd);
    chk({tag, ".rbit"}, g_rb, erb);
    @(negedge clk);
    chk({tag, ".ack_one_cycle"}, {r0_ack, r1_ack}, 2'b00);
  endtask

  typedef struct {
    bit         who, rw, bb, ind;
    logic [7:0] addr, pos, din;
    bit         bin;
    logic [7:0] erd;
    bit         erb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] erd, ptr;
    bit erb;
    int n, cyc, nmis;
    bit who, rw, bb, ind, bin;
    logic [7:0] addr, pos, din;

    tbl[0] = '{0, 0, 1, 0, 8'h30, 8'h00, 8'h55, 0, 8'h00, 0};
    tbl[1] = '{1, 0, 1, 0, 8'h20, 8'h00, 8'h87, 0, 8'h00, 0};
    tbl[2] = '{0, 1, 0, 0, 8'h20, 8'h02, 8'h00, 0, 8'h87, 1};
    tbl[3] = '{1, 0, 1, 0, 8'h00, 8'h00, 8'h30, 0, 8'h87, 1};
    tbl[4] = '{0, 1, 1, 1, 8'h00, 8'h00, 8'h00, 0, 8'h55, 1};
    tbl[5] = '{0, 0, 0, 0, 8'h20, 8'h07, 8'h00, 0, 8'h55, 1};
    tbl[6] = '{0, 1, 1, 0, 8'h20, 8'h03, 8'h00, 0, 8'h07, 0};
    tbl[7] = '{1, 1, 1, 0, 8'h30, 8'h00, 8'h00, 0, 8'h55, 1};

    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hA5;
    m_rd = 8'h00; m_rb = 0;
    rst = 1; mem_init = 1;
    r0_req = 0; r0_rw = 1; r0_bb = 1; r0_ind = 0; r0_addr = 0; r0_pos = 0; r0_din = 0; r0_bin = 0;
    r1_req = 0; r1_rw = 1; r1_addr = 0; r1_din = 0;
    repeat (2) @(negedge clk);
    mem_init = 0;
    chk("reset.ram_bus", ram_bus(), RAM_IDLE_BUS);
    chk("reset.acks", {r0_ack, r1_ack}, 2'b00);
    chk("reset.rdata", rdata, 8'h00);
    chk("reset.rbit", rbit, 0);
    rst = 0;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      model(tbl[i].rw, tbl[i].bb, tbl[i].ind, tbl[i].addr, tbl[i].pos,
            tbl[i].din, tbl[i].bin, erd, erb, ptr);
      txn($sformatf("vec%0d", i), tbl[i].who, tbl[i].rw, tbl[i].bb, tbl[i].ind,
          tbl[i].addr, tbl[i].pos, tbl[i].din, tbl[i].bin, ptr, tbl[i].erd, tbl[i].erb);
    end
    chk("vec.mem30", mem[8'h30], 8'h55);

    // Arbitration after reset (last grant was r1 before reset)
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    m_rd = 8'h00; m_rb = 0;
    r0_rw = 1; r0_bb = 1; r0_ind = 0; r0_addr = 8'h20; r0_pos = 8'h01;
    r1_rw = 1; r1_addr = 8'h30;
    r0_req = 1; r1_req = 1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (r0_ack || r1_ack) begin
        chk($sformatf("arb.excl%0d", n), r0_ack & r1_ack, 0);
        chk($sformatf("arb.who%0d", n), r1_ack, (n % 2 == 0) ? 1 : 0);
        chk($sformatf("arb.rdata%0d", n), rdata, r1_ack ? shadow[8'h30] : shadow[8'h20]);
        $display("arb%0d r0_ack=%0d r1_ack=%0d rdata=%02h", n, r0_ack, r1_ack, rdata);
        n++;
      end
    end
    r0_req = 0; r1_req = 0;
    chk("arb.count", n, 4);
    model(1, 1, 0, 8'h20, 8'h01, 8'h00, 0, erd, erb, ptr);
    @(negedge clk);

    // Reset in the middle of a write access
    r0_rw = 0; r0_bb = 1; r0_ind = 0; r0_addr = 8'h40; r0_pos = 0; r0_din = 8'h55; r0_req = 1;
    @(negedge clk);
    chk("rst.cs_low_in_acc", ram_cs, 0);
    rst = 1;
    #1;
    chk("rst.cs_immediate", ram_cs, 1);
    chk("rst.no_ack", {r0_ack, r1_ack}, 2'b00);
    r0_req = 0;
    @(negedge clk);
    chk("rst.mem40", mem[8'h40], shadow[8'h40]);
    chk("rst.bus", ram_bus(), RAM_IDLE_BUS);
    chk("rst.rdata", rdata, 8'h00);
    $display("rst_abort mem40=%02h ram_cs=%0d rdata=%02h", mem[8'h40], ram_cs, rdata);
    rst = 0;
    m_rd = 8'h00; m_rb = 0;
    repeat (2) @(negedge clk);
    chk("rst.still_idle", {ram_cs, r0_ack, r1_ack}, 3'b100);
    model(1, 1, 0, 8'h40, 8'h00, 8'h00, 0, erd, erb, ptr);
    txn("post_rst", 0, 1, 1, 0, 8'h40, 8'h00, 8'h00, 0, ptr, erd, erb);

    // Random traffic against the shadow model
    for (int i = 0; i < 60; i++) begin
      who = 1'($urandom);
      rw = 1'($urandom);
      addr = 8'($urandom);
      din = 8'($urandom);
      if (who) begin
        bb = 1; ind = 0; pos = 8'h00; bin = 0;
      end else begin
        bb = 1'($urandom); ind = 1'($urandom); pos = 8'($urandom); bin = 1'($urandom);
      end
      model(rw, bb, ind, addr, pos, din, bin, erd, erb, ptr);
      txn($sformatf("rnd%0d", i), who, rw, bb, ind, addr, pos, din, bin, ptr, erd, erb);
    end

    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) nmis++;
    chk("final.mem_vs_model", nmis, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dataram_ctrl.md
DATARAM_CTRL -- requirements
Module: dataram_ctrl

Interface
REQ-001 SHALL have parameter IND_EN, default 1, meaning indirect (@Ri) access is supported; 0 treats r0_ind as 0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have r0_req/r0_rw/r0_bb/r0_ind  input  1 each  core request, 1=read, 1=byte/0=bit, 1=indirect via Ri.
REQ-005 SHALL have r0_addr, r0_pos, r0_din  input  8 each  core address, position (bank for byte, bit index for bit), write byte.
REQ-006 SHALL have r0_bin  input  1  core write bit; r0_ack  output  1  core completion pulse.
REQ-007 SHALL have r1_req/r1_rw  input  1 each, r1_addr/r1_din  input  8 each, r1_ack  output  1  stack/interrupt requester, byte-only, direct-only, pos=0.
REQ-008 SHALL have rdata  output  8  read byte; rbit  output  1  read bit; both shared by requesters.
REQ-009 SHALL have ram_cs (active-low)/ram_rw/ram_bb/ram_bin  output  1 each; ram_addr/ram_pos/ram_din  output  8 each  to DATARAM.
REQ-010 SHALL have ram_dout  input  8, ram_bout  input  1  DATARAM read data, sampled at end of CS-low cycle.

Function
REQ-011 FSM states SHALL be IDLE, IND, ACC, DONE.
REQ-012 IDLE: on edge with any req high, grant and go to IND if granted r0 with r0_ind=1 and IND_EN=1, else ACC.
REQ-013 Arbitration: r1 SHALL win over r0, except r0 SHALL win when both pending and last grant was r1 (no two consecutive r1 grants while r0 waits).
REQ-014 Request fields SHALL be latched at grant; requester changes afterwards SHALL be ignored until DONE.
REQ-015 IND: one cycle ram_cs=0, ram_rw=1, ram_bb=1, ram_addr=latched addr, ram_pos=latched pos; ram_dout latched as pointer; then ACC.
REQ-016 ACC: one cycle ram_cs=0 with latched rw/bb/pos/din/bin; ram_addr=pointer if indirect else latched addr; reads latch ram_dout->rdata, ram_bout->rbit; then DONE.
REQ-017 DONE: granted requester's ack SHALL be high exactly one cycle; rdata/rbit valid then and held until next read completes.
REQ-018 Latency: direct ack SHALL be 2 cycles after grant edge; indirect 3 cycles.
REQ-019 Requester SHALL drop req at edge ending its ack cycle; controller does not sample req in DONE, so no duplicate grant.
REQ-020 Outside IND/ACC ram outputs SHALL idle at cs=1, rw=1, bb=1, addr=0, pos=0, din=0, bin=0.
REQ-021 Bit write SHALL be a single ACC cycle (DATARAM performs bit merge); no read-modify-write.
REQ-022 Writes SHALL never update rdata/rbit.

Reset
REQ-023 rst SHALL immediately force state IDLE, ram outputs to REQ-020 idle values, r0_ack=r1_ack=0, rdata=0, rbit=0, last-grant=r0.
REQ-024 rst during IND/ACC SHALL abort the access with no ack; ram_cs high before next edge, so no write commits.
REQ-025 After rst release, first grant SHALL follow REQ-013 from last-grant=r0.

Structure
REQ-026 Shared package/include dataram_ctrl_pkg SHALL hold state encodings and RAM idle constants.
REQ-027 Arbitration SHALL be sub-module dataram_arb (req0, req1, last-grant in; grant0, grant1 out), combinational.

Verification
REQ-028 r0 direct byte write addr 0x30 din 0x55 -> one cycle cs=0 rw=0 bb=1 addr 0x30 din 0x55; r0_ack 2 cycles after grant.
REQ-029 RAM[0x20]=0x87; r0 bit read addr 0x20 pos 2 -> ram_bb=0, rbit=1 with r0_ack.
REQ-030 RAM bank0 R0=0x30, RAM[0x30]=0x55; r0 indirect read addr 0x00 -> CS cycles addr 0x00 then 0x30; rdata=0x55, ack 3 cycles after grant.
REQ-031 r0, r1 requesting continuously -> grants r1, r0, r1, r0; each ack to correct requester only.
REQ-032 rst asserted mid-ACC of write 0x55 to 0x40 -> ram_cs=1 immediately, no ack, RAM[0x40] unchanged, state IDLE.
